draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_scheduler.sv | 156 +++++++++++++++
 tb/tb_draw_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Frame draw sequencer: arbitrates clear, egg, basket and game-over engines
// onto one VGA write port, with a per-engine watchdog and overrun counting.
module draw_scheduler #(
    parameter int TIMEOUT = 20000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic       clr_done,
    input  logic       egg_done,
    input  logic       bsk_done,
    input  logic       go_done,
    input  logic [7:0] clr_x,
    input  logic [6:0] clr_y,
    input  logic [2:0] clr_c,
    input  logic [7:0] egg_x,
    input  logic [6:0] egg_y,
    input  logic [2:0] egg_c,
    input  logic [7:0] bsk_x,
    input  logic [6:0] bsk_y,
    input  logic [2:0] bsk_c,
    input  logic [7:0] go_x,
    input  logic [6:0] go_y,
    input  logic [2:0] go_c,
    output logic       clr_en,
    output logic       egg_en,
    output logic       bsk_en,
    output logic       go_en,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] overrun_cnt,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        EGG,
        BASKET,
        GAMEOVER,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [14:0] wd;
    logic        engine;
    logic        engine_nx;
    logic        cur_done;
    logic        expire;
    logic        fin;
    logic [7:0]  cur_x;
    logic [6:0]  cur_y;
    logic [2:0]  cur_c;

    always_comb begin
        cur_done = 1'b0;
        cur_x    = clr_x;
        cur_y    = clr_y;
        cur_c    = clr_c;
        case (state)
            CLEAR: begin
                cur_done = clr_done;
            end
            EGG: begin
                cur_done = egg_done;
                cur_x    = egg_x;
                cur_y    = egg_y;
                cur_c    = egg_c;
            end
            BASKET: begin
                cur_done = bsk_done;
                cur_x    = bsk_x;
                cur_y    = bsk_y;
                cur_c    = bsk_c;
            end
            GAMEOVER: begin
                cur_done = go_done;
                cur_x    = go_x;
                cur_y    = go_y;
                cur_c    = go_c;
            end
            default: ;
        endcase
    end

    always_comb begin
        engine = (state == CLEAR) || (state == EGG) ||
                 (state == BASKET) || (state == GAMEOVER);
        expire = engine && (wd == 15'(TIMEOUT - 1));
        fin    = engine && (cur_done || expire);
        state_nx = state;
        case (state)
            IDLE: begin
                if (frame_tick)
                    state_nx = game_over ? GAMEOVER : CLEAR;
            end
            CLEAR:    if (fin) state_nx = EGG;
            EGG:      if (fin) state_nx = BASKET;
            BASKET:   if (fin) state_nx = IDLE;
            GAMEOVER: if (fin) state_nx = HOLD;
            HOLD:     if (!game_over) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        engine_nx = (state_nx == CLEAR) || (state_nx == EGG) ||
                    (state_nx == BASKET) || (state_nx == GAMEOVER);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            clr_en      <= 1'b0;
            egg_en      <= 1'b0;
            bsk_en      <= 1'b0;
            go_en       <= 1'b0;
            plot        <= 1'b0;
            vga_x       <= 8'd0;
            vga_y       <= 7'd0;
            colour      <= 3'd0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun_cnt <= 8'd0;
            timeout_err <= 1'b0;
            wd          <= 15'd0;
        end else begin
            state  <= state_nx;
            clr_en <= state_nx == CLEAR;
            egg_en <= state_nx == EGG;
            bsk_en <= state_nx == BASKET;
            go_en  <= state_nx == GAMEOVER;
            busy   <= engine_nx;
            // First cycle of each engine state is left unplotted for ROM settle
            plot   <= engine_nx && (state_nx == state);
            frame_done <= (state == BASKET) && fin;
            if (state_nx != state)
                wd <= 15'd0;
            else if (engine)
                wd <= wd + 15'd1;
            if (fin && !cur_done)
                timeout_err <= 1'b1;
            if (engine && frame_tick && overrun_cnt != 8'hff)
                overrun_cnt <= overrun_cnt + 8'd1;
            if (engine) begin
                vga_x  <= cur_x;
                vga_y  <= cur_y;
                colour <= cur_c;
            end
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with a phase/age reference model
// compared every cycle, plus literal cycle counts per scenario.
module tb_draw_scheduler;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       game_over = 1'b0;
    logic       clr_done, egg_done, bsk_done, go_done;
    logic [7:0] clr_x = 0, egg_x = 0, bsk_x = 0, go_x = 0;
    logic [6:0] clr_y = 0, egg_y = 0, bsk_y = 0, go_y = 0;
    logic [2:0] clr_c = 0, egg_c = 0, bsk_c = 0, go_c = 0;
    logic       clr_en, egg_en, bsk_en, go_en;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot, busy, frame_done, timeout_err;
    logic [7:0] overrun_cnt;

    localparam int TMO = 20000;

    draw_scheduler #(.TIMEOUT(TMO)) dut (
        .clock(clock), .resetn(resetn),
        .frame_tick(frame_tick), .game_over(game_over),
        .clr_done(clr_done), .egg_done(egg_done),
        .bsk_done(bsk_done), .go_done(go_done),
        .clr_x(clr_x), .clr_y(clr_y), .clr_c(clr_c),
        .egg_x(egg_x), .egg_y(egg_y), .egg_c(egg_c),
        .bsk_x(bsk_x), .bsk_y(bsk_y), .bsk_c(bsk_c),
        .go_x(go_x), .go_y(go_y), .go_c(go_c),
        .clr_en(clr_en), .egg_en(egg_en),
        .bsk_en(bsk_en), .go_en(go_en),
        .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
        .plot(plot), .busy(busy), .frame_done(frame_done),
        .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Engine behaviour: assert done on the lim-th enabled cycle (0 = never)
    int   lim [4] = '{10, 10, 10, 10};
    int   ecnt [4] = '{0, 0, 0, 0};
    logic edone [4] = '{0, 0, 0, 0};
    logic egg_force = 1'b0;
    assign clr_done = edone[0];
    assign egg_done = edone[1] | egg_force;
    assign bsk_done = edone[2];
    assign go_done  = edone[3];

    int encyc [4] = '{0, 0, 0, 0};
    int plot_cyc = 0;
    int fd_cnt = 0;

    // Reference model: phase 0 idle, 1 clear, 2 egg, 3 basket, 4 gameover, 5 hold
    int   m_ph = 0, m_age = 0, m_ovr = 0;
    logic m_tmo = 0, m_fd = 0, started = 0;
    int   m_vx = 0, m_vy = 0, m_c = 0;

    always @(posedge clock) begin
        int  nph;
        logic dn;
        started <= 1'b1;
        if (!resetn) begin
            m_ph = 0; m_age = 0; m_ovr = 0; m_tmo = 0; m_fd = 0;
            m_vx = 0; m_vy = 0; m_c = 0;
        end else begin
            nph = m_ph;
            m_fd = 0;
            if (m_ph >= 1 && m_ph <= 4) begin
                if (frame_tick && m_ovr < 255) m_ovr++;
                case (m_ph)
                    1: begin dn = clr_done; m_vx = clr_x; m_vy = clr_y; m_c = clr_c; end
                    2: begin dn = egg_done; m_vx = egg_x; m_vy = egg_y; m_c = egg_c; end
                    3: begin dn = bsk_done; m_vx = bsk_x; m_vy = bsk_y; m_c = bsk_c; end
                    default: begin dn = go_done; m_vx = go_x; m_vy = go_y; m_c = go_c; end
                endcase
                if (dn || m_age == TMO - 1) begin
                    if (!dn) m_tmo = 1;
                    nph = (m_ph == 3) ? 0 : m_ph + 1;
                    if (m_ph == 3) m_fd = 1;
                end
            end else if (m_ph == 0) begin
                if (frame_tick) nph = game_over ? 4 : 1;
            end else begin
                if (!game_over) nph = 0;
            end
            m_age = (nph != m_ph) ? 0 : m_age + 1;
            m_ph = nph;
        end
    end

    always @(negedge clock) begin
        logic eng;
        logic [3:0] en;
        if (started) begin
            eng = m_ph >= 1 && m_ph <= 4;
            check("clr_en", int'(clr_en), int'(m_ph == 1));
            check("egg_en", int'(egg_en), int'(m_ph == 2));
            check("bsk_en", int'(bsk_en), int'(m_ph == 3));
            check("go_en", int'(go_en), int'(m_ph == 4));
            check("busy", int'(busy), int'(eng));
            check("plot", int'(plot), int'(eng && m_age >= 1));
            check("frame_done", int'(frame_done), int'(m_fd));
            check("overrun_cnt", int'(overrun_cnt), m_ovr);
            check("timeout_err", int'(timeout_err), int'(m_tmo));
            check("vga_x", int'(vga_x), m_vx);
            check("vga_y", int'(vga_y), m_vy);
            check("colour", int'(colour), m_c);
        end
        en = {go_en, bsk_en, egg_en, clr_en};
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                encyc[i]++;
                ecnt[i]++;
                edone[i] = (lim[i] != 0) && (ecnt[i] == lim[i]);
            end else begin
                ecnt[i] = 0;
                edone[i] = 1'b0;
            end
        end
        if (plot) plot_cyc++;
        if (frame_done) fd_cnt++;
        clr_x = 8'($urandom); clr_y = 7'($urandom); clr_c = 3'($urandom);
        egg_x = 8'($urandom); egg_y = 7'($urandom); egg_c = 3'($urandom);
        bsk_x = 8'($urandom); bsk_y = 7'($urandom); bsk_c = 3'($urandom);
        go_x = 8'($urandom); go_y = 7'($urandom); go_c = 3'($urandom);
    end

    task automatic reset_counts();
        for (int i = 0; i < 4; i++) encyc[i] = 0;
        plot_cyc = 0;
        fd_cnt = 0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle(int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clock);
            n++;
        end
        check("wait_idle_bound", int'(busy), 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_en"}, int'({clr_en, egg_en, bsk_en, go_en}), 0);
        check({tag, "_plot"}, int'(plot), 0);
        check({tag, "_vga"}, int'({vga_x, vga_y, colour}), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_fd"}, int'(frame_done), 0);
        check({tag, "_ovr"}, int'(overrun_cnt), 0);
        check({tag, "_tmo"}, int'(timeout_err), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Normal frame, each engine done on its 10th enabled cycle
        reset_counts();
        pulse_tick();
        wait_idle(200);
        check("s1_clr_cycles", encyc[0], 10);
        check("s1_egg_cycles", encyc[1], 10);
        check("s1_bsk_cycles", encyc[2], 10);
        check("s1_plot_cycles", plot_cyc, 27);
        check("s1_frame_done", fd_cnt, 1);
        check("s1_busy", int'(busy), 0);

        // egg_done pulsed during CLEAR is ignored
        reset_counts();
        pulse_tick();
        repeat (3) @(negedge clock);
        egg_force = 1'b1;
        @(negedge clock);
        egg_force = 1'b0;
        wait_idle(200);
        check("s6_clr_cycles", encyc[0], 10);
        check("s6_egg_cycles", encyc[1], 10);

        // Game-over screen then HOLD
        reset_counts();
        lim[3] = 19200;
        game_over = 1'b1;
        pulse_tick();
        wait_idle(25000);
        check("s2_go_cycles", encyc[3], 19200);
        check("s2_go_en", int'(go_en), 0);
        check("s2_fd", fd_cnt, 0);
        repeat (3) pulse_tick();
        check("s2_hold_ovr", int'(overrun_cnt), 0);
        check("s2_hold_clr", int'(clr_en), 0);
        game_over = 1'b0;
        repeat (2) @(negedge clock);
        pulse_tick();
        check("s2_restart_clr", int'(clr_en), 1);
        wait_idle(200);

        // Egg engine hangs, watchdog forces BASKET
        reset_counts();
        lim[1] = 0;
        check("s3_tmo_before", int'(timeout_err), 0);
        pulse_tick();
        wait_idle(25000);
        check("s3_egg_cycles", encyc[1], 20000);
        check("s3_bsk_cycles", encyc[2], 10);
        check("s3_tmo", int'(timeout_err), 1);
        lim[1] = 10;

        // Tick held through a whole frame, incl. the bsk_done cycle
        frame_tick = 1'b1;
        repeat (31) @(negedge clock);
        frame_tick = 1'b0;
        wait_idle(200);
        check("s4_ovr_frame", int'(overrun_cnt), 30);
        frame_tick = 1'b1;
        repeat (320) @(negedge clock);
        frame_tick = 1'b0;
        wait_idle(200);
        check("s4_ovr_sat", int'(overrun_cnt), 255);

        // Reset during EGG
        pulse_tick();
        n = 0;
        while (!egg_en && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("s5_reach_egg", int'(egg_en), 1);
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check_reset_vals("s5");
        @(negedge clock);
        check("s5_idle", int'(busy), 0);
        pulse_tick();
        check("s5_clr", int'(clr_en), 1);
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
